spike_event_logger: RTL and testbench

Downstream consumer of the LIF neuron's `spike` output. Detects each rising edge of the level-type spike signal, stamps it with a free-running cycle timestamp and a snapshot of the neuron membrane `state`, and buffers the events in a small FIFO drained over a valid/ready interface. It also keeps a saturating spike count and a sticky overflow flag for readout by the surrounding tile logic.

---
 rtl/lif_pkg.sv | 14 +
 rtl/lif_event_fifo.sv | 51 +++++
 rtl/spike_event_logger.sv | 122 ++++++++++++
 tb/tb_spike_event_logger.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared constants and event record for the LIF neuron tile
package lif_pkg;

  localparam int STATE_W       = 8;
  localparam int TS_WIDTH_DEF  = 8;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int DEPTH_DEF     = 4;

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0] ts;
    logic [STATE_W-1:0]      state;
  } spike_event_t;

endpackage

// File: rtl/lif_event_fifo.sv
// rtl/lif_event_fifo.sv - generic synchronous FIFO with push/pop/clear
// Pointers carry one extra wrap bit so full and empty never alias.
module lif_event_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamped spike edge logger with FIFO, count, overflow
// Optional windowed rate output enabled by defining SPIKE_LOGGER_RATE_EN.
module spike_event_logger
  import lif_pkg::*;
#(
  parameter int TS_WIDTH  = TS_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int WIN_LOG2  = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        spike,
  input  logic [STATE_W-1:0]          state,
  input  logic                        clear,
  input  logic                        ev_ready,
  output logic                        ev_valid,
  output logic [TS_WIDTH+STATE_W-1:0] ev_data,
  output logic [CNT_WIDTH-1:0]        spike_count,
  output logic                        overflow
`ifdef SPIKE_LOGGER_RATE_EN
  ,
  output logic [CNT_WIDTH-1:0]        rate
`endif
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (WIN_LOG2 < 1)) begin : g_bad_cfg
    $error("spike_event_logger: DEPTH must be a power of two >= 2 and WIN_LOG2 >= 1");
  end

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic                spike_d;
  logic                event_det;
  logic [TS_WIDTH-1:0] ts;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                drop;

  assign event_det = spike & ~spike_d;
  assign pop       = ev_valid & ev_ready;
  assign drop      = event_det & fifo_full & ~pop;
  assign ev_valid  = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d     <= 1'b0;
      ts          <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      spike_d     <= 1'b0;
      ts          <= '0;
      spike_count <= '0;
      overflow    <= 1'b0;
    end else begin
      spike_d <= spike;
      ts      <= ts + 1'b1;
      if (event_det && (spike_count != '1)) spike_count <= spike_count + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // The event record is {ts, state} as seen at the edge that detects it.
  lif_event_fifo #(
    .WIDTH (TS_WIDTH + STATE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (rst_n),
    .clear     (clear),
    .push      (event_det),
    .push_data ({ts, state}),
    .pop       (pop),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SPIKE_LOGGER_RATE_EN
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [CNT_WIDTH-1:0] win_acc;
  logic [CNT_WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = win_acc;
    if (event_det && (win_acc != '1)) acc_next = win_acc + 1'b1;
  end

  // The last cycle of a window publishes its own event as part of that window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      win_acc <= '0;
      rate    <= '0;
    end else if (clear) begin
      win_cnt <= '0;
      win_acc <= '0;
      rate    <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (win_cnt == '1) begin
        rate    <= acc_next;
        win_acc <= '0;
      end else begin
        win_acc <= acc_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - directed bench with queue-based reference model
module tb_spike_event_logger;
  import lif_pkg::*;

  localparam int WLOG = 4;
  localparam int WIN  = 16;
  localparam int DEP  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spike;
  logic [7:0]  state;
  logic        clear;
  logic        ev_ready;
  logic        ev_valid;
  logic [15:0] ev_data;
  logic [7:0]  spike_count;
  logic        overflow;
`ifdef SPIKE_LOGGER_RATE_EN
  logic [7:0]  rate;
`endif

  int vectors = 0;
  int errors  = 0;
  bit check_en = 1'b0;

  spike_event_t m_q[$];
  int m_cnt = 0, m_ts = 0, m_win = 0, m_acc = 0, m_rate = 0, sync_cnt = 0;
  bit m_ovf = 1'b0, m_prev = 1'b0;

  always #5 clk = ~clk;

  spike_event_logger #(
    .TS_WIDTH  (8),
    .DEPTH     (DEP),
    .CNT_WIDTH (8),
    .WIN_LOG2  (WLOG)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spike       (spike),
    .state       (state),
    .clear       (clear),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .spike_count (spike_count),
    .overflow    (overflow)
`ifdef SPIKE_LOGGER_RATE_EN
    ,
    .rate        (rate)
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: event list, counters and timestamp advanced per active edge.
  always @(posedge clk or negedge reset_n) begin
    bit ev;
    if (!reset_n) begin
      m_q.delete();
      m_cnt = 0; m_ovf = 0; m_ts = 0; m_prev = 0;
      m_win = 0; m_acc = 0; m_rate = 0; sync_cnt = 0;
    end else if (sync_cnt < 2) begin
      sync_cnt++;
    end else if (clear) begin
      m_q.delete();
      m_cnt = 0; m_ovf = 0; m_ts = 0; m_prev = 0;
      m_win = 0; m_acc = 0; m_rate = 0;
    end else begin
      ev = spike && !m_prev;
      if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEP) m_q.push_back(spike_event_t'{ts: 8'(m_ts), state: state});
        else m_ovf = 1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_acc = (m_acc < 255) ? m_acc + 1 : 255;
      end
      if (m_win == WIN - 1) begin
        m_rate = m_acc;
        m_acc  = 0;
      end
      m_win  = (m_win + 1) % WIN;
      m_prev = spike;
      m_ts   = (m_ts + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ev_valid", ev_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("ev_data", ev_data, m_q[0]);
      chk("spike_count", spike_count, m_cnt);
      chk("overflow", overflow, m_ovf);
`ifdef SPIKE_LOGGER_RATE_EN
      chk("rate", rate, m_rate);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ts(input int t);
    int n = 0;
    while (m_ts != t && n < 600) begin
      tick();
      n++;
    end
    if (m_ts != t) begin
      vectors++;
      errors++;
      $display("FAIL wait_ts: timestamp %0d never reached target %0d", m_ts, t);
    end
  endtask

  task automatic pulse(input logic [7:0] s);
    spike = 1'b1;
    state = s;
    tick();
    spike = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          nv;
    logic [15:0] d;
    logic [15:0] e2 [4];
    e2 = '{16'h0210, 16'h0411, 16'h0612, 16'h0813};
    nv = 0;
    d  = '0;

    reset_n = 1'b0; spike = 1'b0; state = 8'h00; clear = 1'b0; ev_ready = 1'b0;
    tick(); tick();
    check_en = 1'b1;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_data", ev_data, 16'h0000);
    chk("rst_count", spike_count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;

    // Held spike yields a single event stamped with the rising-edge timestamp.
    wait_ts(10);
    ev_ready = 1'b1;
    state = 8'hC8;
    spike = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) spike = 1'b0;
      if (ev_valid) begin
        nv++;
        d = ev_data;
      end
    end
    chk("t1_events", nv, 1);
    chk("t1_data", d, 16'h0AC8);
    chk("t1_count", spike_count, 1);

    // Six edges into a stalled 4-deep FIFO.
    ev_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      spike = 1'b1;
      state = 8'(8'h10 + i);
      tick();
      chk($sformatf("t2_overflow_edge%0d", i + 1), overflow, i >= 4);
      spike = 1'b0;
      tick();
    end
    chk("t2_count", spike_count, 6);
    ev_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t2_drain%0d", j), ev_data, e2[j]);
      tick();
    end
    chk("t2_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // Full FIFO with simultaneous pop and push: nothing lost.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 4; i++) pulse(8'(8'h30 + i));
    chk("t3_pre_overflow", overflow, 0);
    spike = 1'b1; state = 8'h3F; ev_ready = 1'b1;
    tick();
    spike = 1'b0; ev_ready = 1'b0;
    chk("t3_overflow", overflow, 0);
    chk("t3_count", spike_count, 5);
    ev_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (ev_valid) nv++;
      tick();
    end
    chk("t3_occupancy", nv, 4);
    ev_ready = 1'b0;

    // Timestamp wrap.
    clear = 1'b1; tick(); clear = 1'b0;
    wait_ts(255);
    spike = 1'b1; state = 8'hAA;
    tick();
    spike = 1'b0;
    tick(); tick();
    pulse(8'hBB);
    chk("t4_first", ev_data, 16'hFFAA);
    ev_ready = 1'b1;
    tick();
    chk("t4_second", ev_data, 16'h02BB);
    tick();
    chk("t4_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // Clear coinciding with an edge while the FIFO holds an event.
    pulse(8'h55);
    chk("t5_pre_valid", ev_valid, 1);
    spike = 1'b1; clear = 1'b1;
    tick();
    spike = 1'b0; clear = 1'b0;
    chk("t5_valid", ev_valid, 0);
    chk("t5_count", spike_count, 0);
    tick(); tick();
    chk("t5_valid_later", ev_valid, 0);
    chk("t5_count_later", spike_count, 0);

    // Asynchronous reset in the middle of a drain.
    pulse(8'h61); pulse(8'h62); pulse(8'h63);
    chk("t6_pre_count", spike_count, 3);
    ev_ready = 1'b1;
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("t6_ev_valid", ev_valid, 0);
    chk("t6_ev_data", ev_data, 16'h0000);
    chk("t6_count", spike_count, 0);
    chk("t6_overflow", overflow, 0);
`ifdef SPIKE_LOGGER_RATE_EN
    chk("t6_rate", rate, 0);
`endif
    tick(); tick();
    reset_n = 1'b1;

    // Three events in window 0, none in window 1.
    wait_ts(2);  pulse(8'h71);
    wait_ts(5);  pulse(8'h72);
    wait_ts(8);  pulse(8'h73);
    chk("t7_count", spike_count, 3);
`ifdef SPIKE_LOGGER_RATE_EN
    wait_ts(15);
    chk("t7_rate_w0_open", rate, 0);
    tick();
    chk("t7_rate_w0", rate, 3);
    wait_ts(31);
    chk("t7_rate_w1_open", rate, 3);
    tick();
    chk("t7_rate_w1", rate, 0);
`endif
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
